// File: rtl/wishbus_arb_n_if.sv
// Bus bundle for the N-user round-robin memory arbiter.
// The slave modport is the arbiter's view. The master modport is the
// environment's view: the users plus the memory behind the arbiter.
interface wishbus_arb_n_if #(
    parameter int NUM_USERS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16
);
    // User side: requests in, completion pulses and shared read data out
    logic [NUM_USERS-1:0]        usr_en_i;
    logic [NUM_USERS-1:0]        usr_stb_i;
    logic [NUM_USERS-1:0]        usr_we_i;
    logic [NUM_USERS*ADDR_W-1:0] usr_addr_i;
    logic [NUM_USERS*DATA_W-1:0] usr_dat_i;
    logic [NUM_USERS-1:0]        usr_ack_o;
    logic [NUM_USERS-1:0]        usr_err_o;
    logic [DATA_W-1:0]           usr_dat_o;

    // Memory side: a single outstanding request
    logic                        mem_stb_o;
    logic                        mem_we_o;
    logic [ADDR_W-1:0]           mem_addr_o;
    logic [DATA_W-1:0]           mem_dat_o;
    logic                        mem_ack_i;
    logic [DATA_W-1:0]           mem_dat_i;

    modport slave (
        input  usr_en_i, usr_stb_i, usr_we_i, usr_addr_i, usr_dat_i,
        input  mem_ack_i, mem_dat_i,
        output usr_ack_o, usr_err_o, usr_dat_o,
        output mem_stb_o, mem_we_o, mem_addr_o, mem_dat_o
    );

    modport master (
        output usr_en_i, usr_stb_i, usr_we_i, usr_addr_i, usr_dat_i,
        output mem_ack_i, mem_dat_i,
        input  usr_ack_o, usr_err_o, usr_dat_o,
        input  mem_stb_o, mem_we_o, mem_addr_o, mem_dat_o
    );
endinterface

// File: rtl/wishbus_arb_n.sv
// Round-robin arbiter that funnels NUM_USERS requesters onto one memory port.
// One transaction is in flight at a time: IDLE picks a winner, BUSY waits for
// the memory ack or the timeout, and DONE is a one-cycle gap before the next pick.
// Every output is a register.
module wishbus_arb_n #(
    parameter int NUM_USERS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    wishbus_arb_n_if.slave bus
);

    localparam int GNT_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
    // A zero TIMEOUT disables the timeout. Keep one counter bit so the width stays legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t               state;
    logic [GNT_W-1:0]     grant;
    logic [GNT_W-1:0]     last_grant;
    logic [CNT_W-1:0]     tmo_cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic                 timeout_hit;

    logic [NUM_USERS-1:0] active;
    logic                 pick_valid;
    logic [GNT_W-1:0]     pick;
    logic                 pick_we;
    logic [ADDR_W-1:0]    pick_addr;
    logic [DATA_W-1:0]    pick_dat;
    int                   idx;

    // Only enabled users with a raised strobe compete for the bus
    assign active = bus.usr_stb_i & bus.usr_en_i;

    // Round-robin search from last_grant+1, wrapping.
    // The loop walks the candidates from farthest to nearest, so the nearest active user is written last and wins.
    always_comb begin
        // NOTE: every combinational output gets a default before the loop, so no path leaves one unassigned and no latch is inferred.
        pick_valid = 1'b0;
        pick       = '0;
        pick_we    = 1'b0;
        pick_addr  = '0;
        pick_dat   = '0;
        idx        = 0;
        for (int i = NUM_USERS; i >= 1; i--) begin
            idx = (int'(last_grant) + i) % NUM_USERS;
            if (active[idx]) begin
                pick_valid = 1'b1;
                pick       = GNT_W'(idx);
                pick_we    = bus.usr_we_i[idx];
                pick_addr  = bus.usr_addr_i[idx*ADDR_W +: ADDR_W];
                pick_dat   = bus.usr_dat_i[idx*DATA_W +: DATA_W];
            end
        end
    end

    // The timeout fires on the BUSY edge where the cycle count would reach TIMEOUT
    assign cnt_next    = tmo_cnt + CNT_W'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_next == TMO_LIMIT);

    // Controller: state, grant bookkeeping, timeout counter and all registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= ST_IDLE;
            grant          <= '0;
            last_grant     <= GNT_W'(NUM_USERS - 1);
            tmo_cnt        <= '0;
            bus.mem_stb_o  <= 1'b0;
            bus.mem_we_o   <= 1'b1;
            bus.mem_addr_o <= '0;
            bus.mem_dat_o  <= '0;
            bus.usr_ack_o  <= '0;
            bus.usr_err_o  <= '0;
            bus.usr_dat_o  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every right-hand side reads the value from before this edge.
            // ack and err are one-cycle pulses. They clear here unless a branch below sets them again.
            bus.usr_ack_o <= '0;
            bus.usr_err_o <= '0;

            unique case (state)
                ST_IDLE: begin
                    // Memory acks that arrive while idle are ignored
                    if (pick_valid) begin
                        grant          <= pick;
                        bus.mem_we_o   <= pick_we;
                        bus.mem_addr_o <= pick_addr;
                        bus.mem_dat_o  <= pick_dat;
                        bus.mem_stb_o  <= 1'b1;
                        tmo_cnt        <= '0;
                        state          <= ST_BUSY;
                    end
                end

                ST_BUSY: begin
                    // The mem_* outputs hold their values, whatever the users do now.
                    // An ack beats a timeout that lands on the same edge.
                    if (bus.mem_ack_i) begin
                        bus.mem_stb_o    <= 1'b0;
                        if (bus.mem_we_o) begin
                            bus.usr_dat_o <= bus.mem_dat_i;
                        end
                        bus.usr_ack_o[grant] <= 1'b1;
                        last_grant       <= grant;
                        state            <= ST_DONE;
                    end else if (timeout_hit) begin
                        bus.mem_stb_o    <= 1'b0;
                        bus.usr_err_o[grant] <= 1'b1;
                        last_grant       <= grant;
                        tmo_cnt          <= cnt_next;
                        state            <= ST_DONE;
                    end else begin
                        tmo_cnt          <= cnt_next;
                    end
                end

                ST_DONE: begin
                    // One dead cycle. The finished user drops its strobe here, so it cannot win again by mistake.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wishbus_arb_n.sv
// Bench for wishbus_arb_n with 4 users and TIMEOUT=8.
// Directed scenarios come first, then randomized traffic.
// A model that works at the transaction level predicts each grant, the completion cycle and the read data.
module tb_wishbus_arb_n;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 16;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    wishbus_arb_n_if #(.NUM_USERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    wishbus_arb_n #(
        .NUM_USERS(N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TIMEOUT  (TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: the requests each user holds, the enables, the last grant and the read data
    logic [N-1:0]  pend;
    logic [N-1:0]  en;
    logic          req_we   [N];
    logic [AW-1:0] req_addr [N];
    logic [DW-1:0] req_dat  [N];
    int            last_g;
    logic [DW-1:0] rd_model;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        bus.usr_en_i  = en;
        bus.usr_stb_i = pend;
        for (int k = 0; k < N; k++) begin
            bus.usr_we_i[k]               = req_we[k];
            bus.usr_addr_i[k*AW +: AW]    = req_addr[k];
            bus.usr_dat_i[k*DW +: DW]     = req_dat[k];
        end
    endtask

    task automatic set_req(input int u, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[u]   = we;
        req_addr[u] = a;
        req_dat[u]  = d;
        pend[u]     = 1'b1;
    endtask

    // Rotate the request mask so the search start sits at bit 0, then take the lowest set bit
    function automatic int rr_pick(input logic [N-1:0] m, input int last);
        logic [2*N-1:0] dbl;
        dbl = {m, m} >> (last + 1);
        for (int j = 0; j < N; j++) begin
            if (dbl[j]) return (last + 1 + j) % N;
        end
        return -1;
    endfunction

    // One arbitration edge: the model predicts the winner, or no grant at all
    task automatic expect_grant(output int w);
        w = rr_pick(pend & en, last_g);
        tick();
        if (w < 0) begin
            check("no_grant_stb", bus.mem_stb_o, 1'b0);
        end else begin
            check("grant_stb", bus.mem_stb_o, 1'b1);
            check("grant_addr", bus.mem_addr_o, req_addr[w]);
            check("grant_we", bus.mem_we_o, req_we[w]);
            check("grant_dat", bus.mem_dat_o, req_dat[w]);
        end
    endtask

    // Run a granted transaction. The memory acks d cycles after mem_stb rises.
    // When d is TO+1, the timeout fires first and the ack lands in DONE.
    // If disturb is set, the winner's enable and address change mid-flight.
    task automatic serve(input int w, input int d, input logic [DW-1:0] rdat, input bit disturb);
        logic [AW-1:0] a0;
        logic          we0;
        bit            done;
        a0   = req_addr[w];
        we0  = req_we[w];
        done = 1'b0;
        for (int k = 1; k <= TO && !done; k++) begin
            if (k == d) begin
                bus.mem_ack_i = 1'b1;
                bus.mem_dat_i = rdat;
            end
            if (k == 1 && disturb) begin
                en[w]       = 1'b0;
                req_addr[w] = ~req_addr[w];
                drive();
            end
            tick();
            bus.mem_ack_i = 1'b0;
            bus.mem_dat_i = DW'($urandom);
            if (k == d) begin
                if (we0) rd_model = rdat;
                check("ack_pulse", bus.usr_ack_o, 64'(1) << w);
                check("ack_no_err", bus.usr_err_o, 0);
                check("ack_stb_low", bus.mem_stb_o, 1'b0);
                check("ack_rdata", bus.usr_dat_o, rd_model);
                done = 1'b1;
            end else if (k == TO) begin
                check("tmo_err", bus.usr_err_o, 64'(1) << w);
                check("tmo_no_ack", bus.usr_ack_o, 0);
                check("tmo_stb_low", bus.mem_stb_o, 1'b0);
                check("tmo_rdata", bus.usr_dat_o, rd_model);
                done = 1'b1;
            end else begin
                check("busy_stb", bus.mem_stb_o, 1'b1);
                check("busy_addr", bus.mem_addr_o, a0);
                check("busy_quiet", {bus.usr_ack_o, bus.usr_err_o}, 0);
            end
        end
        last_g  = w;
        pend[w] = 1'b0;
        if (disturb) en[w] = 1'b1;
        drive();
        if (d == TO + 1) begin
            bus.mem_ack_i = 1'b1;
            bus.mem_dat_i = 16'h5A5A;
        end
        tick();
        bus.mem_ack_i = 1'b0;
        check("done_quiet", {bus.usr_ack_o, bus.usr_err_o, bus.mem_stb_o}, 0);
        check("done_rdata", bus.usr_dat_o, rd_model);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int w;
        int exp_order [6];
        logic [AW-1:0] a;

        exp_order = '{0, 1, 3, 0, 1, 3};
        pend = '0;
        en   = '0;
        for (int k = 0; k < N; k++) begin
            req_we[k]   = 1'b0;
            req_addr[k] = '0;
            req_dat[k]  = '0;
        end
        bus.mem_ack_i = 1'b0;
        bus.mem_dat_i = '0;
        drive();

        // Raise the reset before any clock edge. Only the asynchronous path can set the outputs here.
        #1 rst = 1'b1;
        #1;
        check("rst_stb", bus.mem_stb_o, 1'b0);
        check("rst_we", bus.mem_we_o, 1'b1);
        check("rst_addr", bus.mem_addr_o, 0);
        check("rst_dat", bus.mem_dat_o, 0);
        check("rst_ack", bus.usr_ack_o, 0);
        check("rst_err", bus.usr_err_o, 0);
        check("rst_rdata", bus.usr_dat_o, 0);
        tick();
        tick();
        rst      = 1'b0;
        last_g   = N - 1;
        rd_model = '0;

        // Round robin among users 0, 1 and 3. Each re-requests after its ack. User 2 stays off.
        en = '1;
        for (int i = 0; i < 6; i++) begin
            for (int u = 0; u < N; u++) begin
                if (u != 2 && !pend[u]) set_req(u, 1'b0, 32'h100 * u, 16'(u + 16'h40));
            end
            drive();
            expect_grant(w);
            check("rr_order", bus.mem_addr_o, 32'h100 * exp_order[i]);
            serve(w, 1, 16'h0, 1'b0);
        end

        // A single read from user 2 at address 0x10. The memory acks two cycles after mem_stb rises.
        pend = '0;
        set_req(2, 1'b1, 32'h10, 16'h1234);
        drive();
        expect_grant(w);
        check("single_read_addr", bus.mem_addr_o, 32'h10);
        check("single_read_we", bus.mem_we_o, 1'b1);
        serve(w, 2, 16'hBEEF, 1'b0);
        check("single_read_dat", bus.usr_dat_o, 16'hBEEF);

        // Enable mask: user 1 waits while its enable is low
        en = 4'b1101;
        set_req(1, 1'b0, 32'h2222, 16'h0101);
        drive();
        expect_grant(w);
        expect_grant(w);
        en = 4'b1111;
        drive();
        expect_grant(w);
        check("en_grant_user1", bus.mem_addr_o, 32'h2222);
        serve(w, 3, 16'h0, 1'b0);

        // Timeout: a write from user 0 gets no ack, and the late ack lands in DONE. Then user 3 is served.
        set_req(0, 1'b0, 32'hA0, 16'h7777);
        drive();
        expect_grant(w);
        serve(w, TO + 1, 16'hDEAD, 1'b0);
        set_req(3, 1'b1, 32'h3030, 16'h0);
        drive();
        expect_grant(w);
        check("post_tmo_grant", bus.mem_addr_o, 32'h3030);
        serve(w, 1, 16'h4321, 1'b0);

        // The ack lands on the timeout cycle. The ack wins and usr_err stays low.
        set_req(1, 1'b1, 32'hB0, 16'h0);
        drive();
        expect_grant(w);
        serve(w, TO, 16'hC0DE, 1'b0);
        check("collision_rdata", bus.usr_dat_o, 16'hC0DE);

        // Changing the winner's enable and address mid-transaction has no effect
        set_req(2, 1'b1, 32'hC0, 16'h0);
        drive();
        expect_grant(w);
        serve(w, 4, 16'h1357, 1'b1);

        // Randomized traffic: requests, enables, read/write, ack delays and disturbances all vary
        for (int it = 0; it < 200; it++) begin
            for (int u = 0; u < N; u++) begin
                if (!pend[u] && $urandom_range(0, 1) == 1) begin
                    a = AW'($urandom);
                    a[AW-1 -: 4] = 4'(u);
                    set_req(u, 1'($urandom_range(0, 1)), a, DW'($urandom));
                end
            end
            if (pend == '0) begin
                a = AW'($urandom);
                a[AW-1 -: 4] = 4'(1);
                set_req(1, 1'b1, a, DW'($urandom));
            end
            en = N'($urandom);
            if ((pend & en) == '0) en = '1;
            drive();
            expect_grant(w);
            serve(w, $urandom_range(1, TO + 1), DW'($urandom), $urandom_range(0, 7) == 0);
        end

        // Assert reset asynchronously mid-BUSY. The transaction is dropped, and user 0 wins first afterwards.
        en   = '1;
        pend = '0;
        set_req(0, 1'b0, 32'hE0, 16'h0);
        drive();
        expect_grant(w);
        serve(w, 1, 16'h0, 1'b0);
        set_req(2, 1'b1, 32'hE2, 16'h0);
        drive();
        expect_grant(w);
        tick();
        #2 rst = 1'b1;
        #1;
        check("async_rst_stb", bus.mem_stb_o, 1'b0);
        check("async_rst_addr", bus.mem_addr_o, 0);
        check("async_rst_pulses", {bus.usr_ack_o, bus.usr_err_o}, 0);
        pend = '0;
        drive();
        tick();
        tick();
        check("rst_hold_pulses", {bus.usr_ack_o, bus.usr_err_o}, 0);
        rst      = 1'b0;
        last_g   = N - 1;
        rd_model = '0;
        set_req(0, 1'b1, 32'hF0, 16'h0);
        set_req(1, 1'b1, 32'hF1, 16'h0);
        drive();
        expect_grant(w);
        check("post_rst_first", bus.mem_addr_o, 32'hF0);
        serve(w, 1, 16'h2468, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wishbus_arb_n.md
WISHBUS_ARB_N -- requirements
Module: wishbus_arb_n

Interface
REQ-001 SHALL have parameter NUM_USERS, default 4: number of user ports, legal range 2..16.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 16: data width.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles without mem_ack_i; 0 disables the timeout.
REQ-005 SHALL have port clk_i, input, 1: single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port usr_en_i, input, NUM_USERS: per-user enable; a disabled user's request is ignored.
REQ-008 SHALL have port usr_stb_i, input, NUM_USERS: per-user request, held high until ack or err.
REQ-009 SHALL have port usr_we_i, input, NUM_USERS: per-user direction; 1 = read, 0 = write.
REQ-010 SHALL have port usr_addr_i, input, NUM_USERS*ADDR_W: packed addresses; user k occupies slice [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port usr_dat_i, input, NUM_USERS*DATA_W: packed write data, sliced the same way.
REQ-012 SHALL have port usr_ack_o, output, NUM_USERS: one-cycle completion pulse.
REQ-013 SHALL have port usr_err_o, output, NUM_USERS: one-cycle timeout pulse.
REQ-014 SHALL have port usr_dat_o, output, DATA_W: shared read data, valid while usr_ack_o is high.
REQ-015 SHALL have ports mem_stb_o, mem_we_o, mem_addr_o and mem_dat_o, outputs, widths 1/1/ADDR_W/DATA_W: memory request.
REQ-016 SHALL have ports mem_ack_i and mem_dat_i, inputs, widths 1/DATA_W: memory completion and read data.

Function
REQ-017 SHALL implement states IDLE, BUSY and DONE; all outputs SHALL be registered.
REQ-018 In IDLE, the active request set SHALL be usr_stb_i & usr_en_i; if the set is empty, the block SHALL stay in IDLE.
REQ-019 Arbitration SHALL be round-robin: search starts at index (last_grant+1) mod NUM_USERS and wraps; the first active index wins.
REQ-020 On grant, the block SHALL latch the winner's we, addr and dat into the mem_* outputs, set mem_stb_o=1 and enter BUSY on the next edge (request-to-mem_stb_o latency is 1 cycle).
REQ-021 In BUSY, mem_* outputs SHALL stay constant; later user input changes, including usr_en_i dropping, SHALL NOT abort or alter the transaction.
REQ-022 In BUSY with mem_ack_i=1, the block SHALL:
- clear mem_stb_o;
- capture mem_dat_i into usr_dat_o when the latched we=1 (usr_dat_o is left unchanged for writes);
- pulse usr_ack_o[grant] for exactly one cycle;
- set last_grant=grant;
- enter DONE.
REQ-023 A timeout cycle counter SHALL count BUSY cycles, width $clog2(TIMEOUT+1), and clear on entering BUSY.
REQ-024 When TIMEOUT>0 and the counter reaches TIMEOUT without ack, the block SHALL clear mem_stb_o, pulse usr_err_o[grant] for one cycle (no ack), set last_grant=grant and enter DONE.
REQ-025 If ack and timeout occur in the same cycle, ack SHALL win.
REQ-026 DONE SHALL last one cycle, then go to IDLE; in DONE no arbitration SHALL occur.
REQ-027 A user SHALL drop usr_stb_i in the cycle after its ack/err; a stb still held in IDLE is treated as a new request.
REQ-028 mem_ack_i arriving in IDLE or DONE SHALL be ignored.
REQ-029 Minimum turnaround SHALL be 3 cycles per transaction when mem_ack_i arrives the cycle after mem_stb_o.

Reset
REQ-030 rst_i=1 SHALL immediately force:
- state=IDLE, last_grant=NUM_USERS-1;
- counter=0;
- mem_stb_o=0, mem_we_o=1, mem_addr_o=0, mem_dat_o=0;
- usr_ack_o=0, usr_err_o=0, usr_dat_o=0.
REQ-031 Reset in BUSY SHALL abandon the transaction with no ack or err pulse.
REQ-032 After rst_i falls, the first grant SHALL go to the lowest active index.

Verification
REQ-033 Single read: user 2 only, read, addr 0x10, memory acks 2 cycles after mem_stb_o with 0xBEEF -> mem_addr_o=0x10, mem_we_o=1, usr_ack_o[2] one cycle, usr_dat_o=0xBEEF.
REQ-034 Round-robin: users 0,1,3 request continuously (restb after each ack) -> grant order 0,1,3,0,1,3; user 2 never granted.
REQ-035 Enable mask: usr_en_i=4'b1101, user 1 stb high -> no grant; user 1 is granted on the cycle after usr_en_i[1] rises.
REQ-036 Timeout: TIMEOUT=8, write from user 0, no ack -> usr_err_o[0] pulses 8 cycles after mem_stb_o rises, no usr_ack_o, next request is granted.
REQ-037 Ack/timeout collision: ack at the exact timeout cycle -> usr_ack_o pulses, usr_err_o stays 0.
REQ-038 Async reset mid-BUSY: rst_i asserted between edges -> mem_stb_o=0 before the next edge; no ack/err; afterwards user 0 is granted first.
